// File: rtl/add_tree_pipe_if.sv
// Beat-in / result-out handshake bundle for add_tree_pipe.
// out_avg exists only when ADD_TREE_NORM_EN is defined.
interface add_tree_pipe_if #(
    parameter int DW   = 16,
    parameter int NTAP = 9
);
    localparam int L  = $clog2(NTAP);
    localparam int SW = DW + L;
    localparam int CW = $clog2(NTAP + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [NTAP*DW-1:0]   in_data;
    logic [NTAP-1:0]      in_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_sum;
    logic [CW-1:0]        out_cnt;
`ifdef ADD_TREE_NORM_EN
    logic [SW-1:0]        out_avg;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_avg
    );
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_avg
    );
`else
    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt
    );
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_sum, out_cnt
    );
`endif
endinterface

// File: rtl/add_tree_pipe.sv
// Pipelined masked adder tree: one registered binary-tree level per stage, with popcount of the mask.
// Define ADD_TREE_NORM_EN to append a rounding right-shift stage producing out_avg.
module add_tree_pipe #(
    parameter int DW    = 16,
    parameter int NTAP  = 9,
    parameter int SHIFT = 3
) (
    input logic           clk,
    input logic           rst_n,
    add_tree_pipe_if.slave bus
);
    localparam int L  = $clog2(NTAP);
    localparam int SW = DW + L;
    localparam int CW = $clog2(NTAP + 1);
    localparam int NH = (NTAP + 1) / 2;

    if (NTAP < 2 || NTAP > 32) begin : g_bad_ntap
        $error("add_tree_pipe: NTAP must be in 2..32");
    end

    function automatic logic [SW-1:0] round_shift(input logic [SW-1:0] s);
        logic [SW:0] t;
        if (SHIFT == 0) return s;
        t = {1'b0, s} + ((SW + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0));
        return SW'(t >> SHIFT);
    endfunction

    logic          adv;
    logic [CW-1:0] cnt_in;
    logic [SW-1:0] opnd  [L][NTAP+1];
    logic [SW-1:0] sum_p [L][NH];
    logic [CW-1:0] cnt_p [L];
    logic [L-1:0]  vld_p;

    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // Operands of every level; slots past the live operand count stay zero so the
    // odd leftover operand passes through as "x + 0".
    always_comb begin
        cnt_in = '0;
        for (int k = 0; k < L; k++)
            for (int i = 0; i <= NTAP; i++)
                opnd[k][i] = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (bus.in_mask[i]) opnd[0][i] = SW'(bus.in_data[i*DW +: DW]);
            cnt_in = cnt_in + CW'(bus.in_mask[i]);
        end
        for (int k = 1; k < L; k++)
            for (int i = 0; i < NH; i++)
                opnd[k][i] = sum_p[k-1][i];
    end

    // Tree stages 1..L
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int k = 0; k < L; k++) begin
                cnt_p[k] <= '0;
                for (int j = 0; j < NH; j++) sum_p[k][j] <= '0;
            end
        end else if (adv) begin
            vld_p[0] <= bus.in_valid;
            if (bus.in_valid) begin
                cnt_p[0] <= cnt_in;
                for (int j = 0; j < NH; j++)
                    sum_p[0][j] <= opnd[0][2*j] + opnd[0][2*j+1];
            end
            for (int k = 1; k < L; k++) begin
                vld_p[k] <= vld_p[k-1];
                cnt_p[k] <= cnt_p[k-1];
                for (int j = 0; j < NH; j++)
                    sum_p[k][j] <= opnd[k][2*j] + opnd[k][2*j+1];
            end
        end
    end

`ifdef ADD_TREE_NORM_EN
    logic          vld_po;
    logic [SW-1:0] sum_po;
    logic [SW-1:0] avg_po;
    logic [CW-1:0] cnt_po;

    // Normalisation stage L+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_po <= 1'b0;
            sum_po <= '0;
            avg_po <= '0;
            cnt_po <= '0;
        end else if (adv) begin
            vld_po <= vld_p[L-1];
            sum_po <= sum_p[L-1][0];
            avg_po <= round_shift(sum_p[L-1][0]);
            cnt_po <= cnt_p[L-1];
        end
    end

    assign bus.out_valid = vld_po;
    assign bus.out_sum   = sum_po;
    assign bus.out_cnt   = cnt_po;
    assign bus.out_avg   = avg_po;
`else
    assign bus.out_valid = vld_p[L-1];
    assign bus.out_sum   = sum_p[L-1][0];
    assign bus.out_cnt   = cnt_p[L-1];
`endif

endmodule
